// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side handshakes and memory-side lines for mem_arbiter.
// The arbiter attaches through the slave modport; its environment uses the master modport.
interface mem_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             f_req;
   logic [WIDTH-1:0] f_addr;
   logic             f_ack;
   logic             f_rvalid;
   logic [WIDTH-1:0] f_rdata;

   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic             d_ack;
   logic             d_done;
   logic [WIDTH-1:0] d_rdata;

   logic [1:0]       mem_mode;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_data_in;
   logic [WIDTH-1:0] mem_data_out;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
      output f_ack, f_rvalid, f_rdata, d_ack, d_done, d_rdata,
      output mem_mode, mem_addr, mem_data_in
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
      input  f_ack, f_rvalid, f_rdata, d_ack, d_done, d_rdata,
      input  mem_mode, mem_addr, mem_data_in
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-access-in-flight arbiter between the fetch port and the data port of the word memory.
// Data port has priority; a fetch is forced after STARVE_MAX consecutive data grants.
module mem_arbiter #(
   parameter int         WIDTH      = 16,
   parameter logic [1:0] MODE_IDLE  = 2'b00,
   parameter logic [1:0] MODE_WRITE = 2'b01,
   parameter logic [1:0] MODE_READ  = 2'b10,
   parameter int         STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   localparam int             SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

   logic [1:0]       state;
   logic             owner_fetch;
   logic             op_write;
   logic [SW-1:0]    starve_cnt;
   logic             grant_d;
   logic             grant_f;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_d = 1'b0;
      grant_f = 1'b0;
      if (state == ST_IDLE) begin
         grant_d = bus.d_req && !(bus.f_req && starve_cnt == STARVE_LIM);
         grant_f = bus.f_req && !grant_d;
      end
   end

   assign bus.d_ack = grant_d;
   assign bus.f_ack = grant_f;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         owner_fetch     <= 1'b0;
         op_write        <= 1'b0;
         starve_cnt      <= '0;
         bus.mem_mode    <= MODE_IDLE;
         bus.mem_addr    <= '0;
         bus.mem_data_in <= '0;
         bus.f_rdata     <= '0;
         bus.d_rdata     <= '0;
         bus.f_rvalid    <= 1'b0;
         bus.d_done      <= 1'b0;
      end else begin
         bus.f_rvalid <= 1'b0;
         bus.d_done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_d) begin
                  bus.mem_mode <= bus.d_we ? MODE_WRITE : MODE_READ;
                  bus.mem_addr <= bus.d_addr;
                  if (bus.d_we) bus.mem_data_in <= bus.d_wdata;
                  owner_fetch <= 1'b0;
                  op_write    <= bus.d_we;
                  state       <= ST_ISSUE;
                  // Counts data grants that jumped ahead of a waiting fetch.
                  if (!bus.f_req)                 starve_cnt <= '0;
                  else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SW'(1);
               end else if (grant_f) begin
                  bus.mem_mode <= MODE_READ;
                  bus.mem_addr <= bus.f_addr;
                  owner_fetch  <= 1'b1;
                  op_write     <= 1'b0;
                  starve_cnt   <= '0;
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               bus.mem_mode <= MODE_IDLE;
               if (op_write) begin
                  bus.d_done <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               // Memory registered its read output at the previous edge.
               if (owner_fetch) begin
                  bus.f_rdata  <= bus.mem_data_out;
                  bus.f_rvalid <= 1'b1;
               end else begin
                  bus.d_rdata <= bus.mem_data_out;
                  bus.d_done  <= 1'b1;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-master front end for the 16-bit word memory. Arbitrates between the instruction-fetch port (read only) and the data port (read/write), drives the memory's mode/address/data-in lines, and returns read data and completion pulses to the requester. One access in flight at a time. Data port has priority, with a fetch starvation guard.

Parameters:
WIDTH, 16, word and address width
MODE_IDLE, 2'b00, memory mode encoding: no access (must match shared signals header)
MODE_WRITE, 2'b01, memory mode encoding: store data_in at address (memModeIn)
MODE_READ, 2'b10, memory mode encoding: load address to data_out (memModeOut)
STARVE_MAX, 4, consecutive data grants allowed while fetch pending before fetch is forced

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
f_req  in  1  fetch read request; held with f_addr until f_ack
f_addr  in  WIDTH  fetch address
f_ack  out  1  combinational; request accepted this cycle
f_rvalid  out  1  registered one-cycle pulse; f_rdata valid
f_rdata  out  WIDTH  fetched word, holds until next f_rvalid
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  write data
d_ack  out  1  combinational; request accepted this cycle
d_done  out  1  registered one-cycle pulse; write complete or d_rdata valid
d_rdata  out  WIDTH  loaded word, holds until next read d_done
mem_mode  out  2  to memory mode
mem_addr  out  WIDTH  to memory address
mem_data_in  out  WIDTH  to memory data_in
mem_data_out  in  WIDTH  from memory data_out (registered inside memory)

Behaviour:
- Reset: state IDLE; mem_mode=MODE_IDLE; mem_addr, mem_data_in, f_rdata, d_rdata = 0; f_ack, d_ack, f_rvalid, d_done = 0; starve counter = 0.
- States: IDLE, ISSUE, CAPTURE.
- IDLE: acks asserted only here, at most one per cycle. Grant: d_req wins unless f_req && starve counter == STARVE_MAX, then fetch wins. Fetch alone -> fetch.
- Accept edge E0: register mem_mode (READ or WRITE per d_we; fetch always READ), mem_addr, mem_data_in (d_wdata for writes, else unchanged); record owner and op; -> ISSUE.
- ISSUE (memory samples at E1): at E1 mem_mode <= MODE_IDLE. Write: d_done=1 for cycle after E1, -> IDLE. Read: -> CAPTURE.
- CAPTURE: at E2 latch mem_data_out into owner's rdata, pulse owner's valid/done for one cycle, -> IDLE.
- Latency: read accepted at E0 -> data visible after E2; write done after E1. Throughput: one read / 3 cycles, one write / 2 cycles. New request may be acked in the same cycle a done/rvalid pulse is high.
- mem_mode is MODE_READ/MODE_WRITE for exactly one cycle per access; otherwise MODE_IDLE.
- Starve counter: +1 on each data grant while f_req is high (saturates at STARVE_MAX); cleared on fetch grant or when f_req is low at a data grant.
- Reset mid-operation (ISSUE or CAPTURE): transaction dropped, no done/rvalid pulse, all outputs to reset values next cycle.
- Requester dropping req before ack: request simply not taken; no side effects.
- Addresses wrap naturally at WIDTH bits; no range checking.

Test Plan:
- Reset held 2 cycles -> mem_mode=00, all acks/valids 0, f_rdata=d_rdata=0x0000.
- Memory preloaded mem[0x0010]=0x1234; f_req, f_addr=0x0010 -> f_ack in accept cycle; mem_mode=10/mem_addr=0x0010 for one cycle; f_rvalid=1, f_rdata=0x1234 exactly 2 cycles after acceptance, single-cycle pulse.
- d_req write 0xBEEF to 0x0100, then read 0x0100 -> mem_mode=01 one cycle, d_done 1 cycle after accept; read returns d_done with d_rdata=0xBEEF.
- f_req and d_req (read 0x0200 = 0x5555) raised same cycle -> d_ack first, d_rdata=0x5555; fetch acked in the next IDLE cycle.
- d_req held for 6 back-to-back reads with f_req pending throughout -> grants D,D,D,D,F,D (fetch served after STARVE_MAX=4).
- Reset asserted during CAPTURE of a fetch read -> no f_rvalid pulse; mem_mode=00; next f_req serviced normally.
